// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if: instruction-memory request/response and decode-side valid/ready bundle
interface ifetch_prefetch_if #(parameter int ADDR_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc4;
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_ready, imem_rvalid, imem_rdata, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_ready, imem_rvalid, imem_rdata, out_ready
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: credit-limited prefetching fetch stage with redirect squash; IFETCH_JUMP_PREDECODE_EN adds j/jal predecode
module ifetch_prefetch #(
  parameter int ADDR_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  input  logic              prog_mode_i,
  ifetch_prefetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  typedef enum logic {RUN, HOLD} state_t;
  state_t            state_q;
  logic              prog_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem [FIFO_DEPTH];
  logic              prog_exit, flush, accept, rsp, keep, push, pop, empty, jump;
  logic [ADDR_W-1:0] flush_pc, jump_pc;
  assign empty     = cnt_q == '0;
  assign prog_exit = prog_q && !prog_mode_i;
  assign flush     = redirect_valid_i || prog_exit;
  assign flush_pc  = redirect_valid_i ? (redirect_pc_i & ~ADDR_W'(3)) : RESET_PC;
  assign bus.imem_req  = reset_i && state_q == RUN && !redirect_valid_i && ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_C;
  assign bus.imem_addr = fetch_pc_q;
  assign accept = bus.imem_req && bus.imem_ready;
  // A response with nothing outstanding is a protocol error and is ignored entirely
  assign rsp    = bus.imem_rvalid && out_q != '0;
  assign keep   = rsp && drop_q == '0;
  assign push   = keep && !flush;
  assign pop    = bus.out_valid && bus.out_ready && !flush;
`ifdef IFETCH_JUMP_PREDECODE_EN
  logic [ADDR_W-1:0] rsp_pc4;
  assign rsp_pc4 = rsp_pc_q + ADDR_W'(4);
  assign jump    = keep && bus.imem_rdata[31:27] == 5'b00001;
  assign jump_pc = (rsp_pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({bus.imem_rdata[25:0], 2'b00});
`else
  assign jump    = 1'b0;
  assign jump_pc = rsp_pc_q;
`endif
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? '0 : instr_mem[rd_q];
  assign bus.out_pc    = empty ? '0 : pc_mem[rd_q];
  assign bus.out_pc4   = empty ? '0 : pc_mem[rd_q] + ADDR_W'(4);
  // Next-state: external flush beats a predecoded jump, which beats sequential advance
  always_comb begin
    fetch_pc_d = flush ? flush_pc : jump ? jump_pc : fetch_pc_q + (accept ? ADDR_W'(4) : '0);
    rsp_pc_d   = flush ? flush_pc : jump ? jump_pc : rsp_pc_q + (keep ? ADDR_W'(4) : '0);
    out_d      = prog_exit ? '0 : out_q + CW'(accept) - CW'(rsp);
    drop_d     = prog_exit ? '0 : (redirect_valid_i || jump) ? out_d : drop_q - CW'(rsp && !keep);
    cnt_d      = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d       = flush ? '0 : wr_q + PW'(push);
    rd_d       = flush ? '0 : rd_q + PW'(pop);
  end
  // Fetch FSM: RUN issues requests, HOLD parks while halted or while the programmer owns memory
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= prog_mode_i ? HOLD : RUN;
      prog_q  <= 1'b0;
    end else begin
      state_q <= (halt_i || prog_mode_i) ? HOLD : RUN;
      prog_q  <= prog_mode_i;
    end
  // PCs, credit/drop counters and FIFO pointers
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  // Entry storage, written at the tail on each kept response
  always_ff @(posedge clock_i)
    if (push) begin
      instr_mem[wr_q] <= bus.imem_rdata;
      pc_mem[wr_q]    <= rsp_pc_q;
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: randomized in-order memory model and instruction-stream reference for ifetch_prefetch
module tb_ifetch_prefetch;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  typedef struct packed {logic [31:0] addr; int due;} req_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic redir = 1'b0, halt = 1'b0, prog = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  req_t pend[$];
  logic [31:0] seen[$];
  int vectors = 0, miscompares = 0, cyc = 0, lat = 1, ready_pct = 100, ordy_pct = 100;
  int accepts = 0, pops = 0, n0, k, prog_left = 0, halt_left = 0;
  logic [31:0] exp_pc = '0, last_pc = '0;
  logic prev_hold = 1'b0, prev_prog = 1'b0, obs_valid = 1'b0, obs_req = 1'b0, jmp_en = 1'b0;
  ifetch_prefetch_if #(.ADDR_W(AW)) bus ();
  ifetch_prefetch #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clock_i(clk), .reset_i(rst_n), .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
    .halt_i(halt), .prog_mode_i(prog), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jmp_en && a == 32'h8) return 32'h0800_0010;
    return {6'h23, a[27:2] ^ 26'h2AB_CDEF};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // One cycle: drive inputs after the falling edge, observe, advance the reference, then cross the rising edge
  task automatic step();
    req_t r;
    logic rv, fl;
    logic [31:0] nx;
    bus.imem_ready = $urandom_range(99) < ready_pct;
    bus.out_ready  = $urandom_range(99) < ordy_pct;
    rv = pend.size() > 0 && pend[0].due <= cyc;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom();
    if (rv) r = pend.pop_front();
    #1;
    obs_valid = bus.out_valid;
    obs_req   = bus.imem_req;
    fl = redir || (prev_prog && !prog);
    if (prev_hold) chk("hold_noreq", 32'(bus.imem_req), 32'd0);
    if (bus.out_valid && bus.out_ready && !fl) begin
      chk("out_pc", bus.out_pc, exp_pc);
      chk("out_instr", bus.out_instr, mem_word(exp_pc));
      chk("out_pc4", bus.out_pc4, exp_pc + 32'd4);
      last_pc = bus.out_pc;
      seen.push_back(bus.out_pc);
      pops++;
      nx = exp_pc + 32'd4;
`ifdef IFETCH_JUMP_PREDECODE_EN
      if (mem_word(exp_pc) >> 27 == 32'd1) nx = {nx[31:28], mem_word(exp_pc) & 32'h03FF_FFFF} & ~32'h0 ^ {4'h0, 28'h0} | 32'h0;
      if (mem_word(exp_pc) >> 27 == 32'd1) nx = {nx[31:28], 28'h0} | ((mem_word(exp_pc) & 32'h03FF_FFFF) << 2);
`endif
      exp_pc = nx;
    end
    if (bus.imem_req && bus.imem_ready) begin
      pend.push_back('{addr: bus.imem_addr, due: cyc + lat});
      accepts++;
      chk("credit", 32'(pend.size() <= DEPTH), 32'd1);
    end
    if (fl) exp_pc = redir ? (redir_pc & ~32'd3) : 32'd0;
    prev_hold = halt || prog;
    prev_prog = prog;
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_pc4", bus.out_pc4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("lat_c0_valid", 32'(obs_valid), 32'd0);
    step();
    chk("lat_c1_valid", 32'(obs_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lat_stream_valid", 32'(obs_valid), 32'd1);
    end
    ordy_pct = 0;
    redir = 1'b1;
    redir_pc = 32'h0;
    accepts = 0;
    step();
    redir = 1'b0;
    repeat (10) step();
    chk("full_accepts", 32'(accepts), 32'(DEPTH));
    chk("full_noreq", 32'(obs_req), 32'd0);
    ordy_pct = 100;
    n0 = pops;
    repeat (4) step();
    chk("drain_rate", 32'(pops - n0), 32'd4);
    lat = 3;
    repeat (8) step();
    redir = 1'b1;
    redir_pc = 32'h43;
    step();
    redir = 1'b0;
    n0 = pops;
    k = 0;
    while (pops == n0 && k < 40) begin step(); k++; end
    chk("redirect_seen", 32'(pops != n0), 32'd1);
    chk("redirect_target", last_pc, 32'h40);
    lat = 1;
    repeat (4) step();
    halt = 1'b1;
    repeat (5) step();
    chk("halt_noreq", 32'(obs_req), 32'd0);
    halt = 1'b0;
    n0 = pops;
    repeat (6) step();
    chk("halt_resume", 32'(pops > n0), 32'd1);
    prog = 1'b1;
    repeat (12) step();
    chk("prog_noreq", 32'(obs_req), 32'd0);
    prog = 1'b0;
    n0 = pops;
    k = 0;
    while (pops == n0 && k < 40) begin step(); k++; end
    chk("prog_exit_seen", 32'(pops != n0), 32'd1);
    chk("prog_exit_pc", last_pc, 32'd0);
`ifdef IFETCH_JUMP_PREDECODE_EN
    jmp_en = 1'b1;
    redir = 1'b1;
    redir_pc = 32'h0;
    step();
    redir = 1'b0;
    seen.delete();
    repeat (15) step();
    n0 = -1;
    for (int i = 0; i + 1 < seen.size(); i++) if (seen[i] == 32'h8 && n0 < 0) n0 = i + 1;
    chk("jump_found", 32'(n0 > 0), 32'd1);
    chk("jump_target", n0 > 0 ? seen[n0] : 32'hFFFF_FFFF, 32'h40);
`endif
    jmp_en = 1'b0;
    redir = 1'b1;
    redir_pc = 32'h100;
    step();
    redir = 1'b0;
    n0 = pops;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        lat = $urandom_range(4, 1);
        ready_pct = $urandom_range(100, 30);
        ordy_pct = $urandom_range(100, 20);
      end
      redir = 1'b0;
      if (prog_left > 0) begin
        prog_left--;
        prog = prog_left > 0;
      end else if ($urandom_range(399) == 0) begin
        prog = 1'b1;
        prog_left = 12;
      end
      if (halt_left > 0) halt_left--;
      else if ($urandom_range(49) == 0) halt_left = $urandom_range(6, 1);
      halt = halt_left > 0;
      if (!(prev_prog && !prog) && $urandom_range(29) == 0) begin
        redir = 1'b1;
        redir_pc = 32'($urandom_range(4095));
      end
      step();
    end
    chk("random_progress", 32'(pops - n0 > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Parametrised successor to the single-cycle instruction fetch stage.
- Decouples PC generation from a variable-latency instruction memory via a request/response handshake and an in-order prefetch FIFO.
- Supports redirect (branch/jr/jump) with squash of in-flight responses, halt hold, and a programming-mode lockout.
- Sits between the PC-redirect logic in decode/execute and instruction memory; feeds decode through a valid/ready pair.

Parameters:
- ADDR_W, 32: PC/address width, at least 16; word-aligned (bits [1:0] always 0).
- FIFO_DEPTH, 4: prefetch entries and maximum outstanding requests; power of 2, at least 2.
- RESET_PC, 32'h0000_0000: PC loaded at reset and on programming-mode exit.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  single-cycle pulse; load redirect_pc and flush.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored and forced to 0.
- halt  in  1  hold: no new requests issued (exit / IO-wait).
- prog_mode  in  1  UART programmer owns instruction memory: no requests issued.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request word address.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  response instruction.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  32  instruction.
- out_pc  out  ADDR_W  address of out_instr.
- out_pc4  out  ADDR_W  out_pc+4, used as branch base and link address.

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0; state=RUN if prog_mode=0, else HOLD.
  - Output reset values: imem_req=0, out_valid=0, out_instr=0, out_pc=0, out_pc4=0.
- FSM states:
  - RUN → HOLD when halt or prog_mode is 1.
  - HOLD → RUN when both are 0.
  - On a prog_mode 1→0 transition, fetch_pc=RESET_PC and FIFO, outstanding and drop are all cleared.
- Issue rules:
  - imem_req=1 only in RUN, when redirect_valid=0, and when (fifo_count + outstanding) < FIFO_DEPTH.
  - imem_addr=fetch_pc.
  - On the imem_req & imem_ready handshake: fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding++.
- Responses:
  - Each imem_rvalid decrements outstanding.
  - If drop>0: discard the response and decrement drop.
  - Otherwise: push {instr, pc} into the FIFO. The PC is tracked by a response-PC register that advances by 4 per kept response.
- Output:
  - out_* present the FIFO head; out_valid = !empty.
  - Pop on out_valid & out_ready.
  - Latency: with imem returning one cycle after accept, the first out_valid occurs 2 cycles after reset release.
  - FIFO_DEPTH back-to-back pops with out_ready=1 are sustained at one instruction per cycle.
- Redirect:
  - The same edge performs: fetch_pc=redirect_pc; response-PC=redirect_pc; FIFO cleared; drop = outstanding minus any response arriving in that cycle (plus the request accepted that cycle — none, since imem_req=0).
  - The next request is issued on the following cycle.
  - Redirect has priority over push, pop and FSM hold.
  - A redirect while in HOLD still updates the PC and flushes.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- FIFO overflow cannot occur (guaranteed by the credit rule). Response with outstanding=0 is a protocol error and is ignored.
- Halt does not squash: in-flight responses still fill the FIFO.

Optional Feature:
- Macro: IFETCH_JUMP_PREDECODE_EN.
- Defined:
  - A kept response whose opcode imem_rdata[31:26] is 6'b000010 (j) or 6'b000011 (jal) is pushed normally.
  - The same cycle also performs an internal redirect to {pc4[ADDR_W-1:28], instr[25:0], 2'b00}: fetch_pc and response-PC are loaded and drop is set to the remaining outstanding count. The FIFO is not cleared.
  - An external redirect_valid in the same cycle wins.
- Undefined: jumps are treated as ordinary instructions; the target is supplied only by redirect_valid.

Test Plan:
- Reset release, imem latency 1, out_ready=1 → out_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles from cycle 2; out_pc4 = out_pc+4.
- out_ready=0 for 10 cycles → exactly FIFO_DEPTH (4) requests issued; imem_req=0 thereafter; FIFO full with PCs 0x0–0xC; released in order.
- Latency 3 with 3 outstanding, redirect_valid pulse with redirect_pc=0x40 → 3 responses dropped; next out_pc=0x40; no stale instruction reaches decode.
- halt=1 for 5 cycles mid-stream → no imem_req; in-flight responses delivered; resume at the correct next PC.
- prog_mode pulse during run → requests stop; after prog_mode falls, FIFO is empty and first out_pc=RESET_PC.
- With IFETCH_JUMP_PREDECODE_EN, instruction 0x0800_0010 at PC 0x8 → following out_pc=0x40, with no decode-issued redirect.
